// File: rtl/akiko_c2p.sv
// Akiko chunky-to-planar / planar-to-chunky converter.
// A DW-pixel x 8-bit buffer is filled through the DATA register in one
// orientation and drained through the same register in the other. The
// CTRL/STATUS register selects the direction and exposes the pointers.
module akiko_c2p #(
    parameter int DW     = 16,
    parameter int PLANES = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [23:1]   address_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    input  logic          rd,
    input  logic          hwr,
    input  logic          lwr,
    input  logic          sel_akiko
);

    localparam int         NB         = DW / 8;
    localparam logic [3:0] PLANES_L   = 4'(PLANES);
    localparam logic [3:0] BYTES_L    = 4'd8;
    localparam logic [7:0] PLANE_MASK = 8'((16'd1 << PLANES) - 16'd1);
    localparam logic [6:0] ADDR_DATA  = 7'b0011100;
    localparam logic [6:0] ADDR_CTRL  = 7'b0011110;

    logic [DW-1:0][7:0] pix_r;
    logic [DW-1:0][7:0] pix_s;
    logic [3:0]         wrptr_r;
    logic [3:0]         wrptr_s;
    logic [3:0]         rdptr_r;
    logic [3:0]         rdptr_s;
    logic               mode_r;
    logic               mode_s;
    logic               wr_prev_r;
    logic               rd_prev_r;

    logic               is_data_s;
    logic               is_ctrl_s;
    logic               wr_both_s;
    logic               wr_fire_s;
    logic               rd_data_s;
    logic               rd_adv_s;
    logic [3:0]         wr_lim_s;
    logic [3:0]         rd_lim_s;
    logic [2:0]         wr_idx_s;
    logic               full_s;
    logic [DW-1:0]      c2p_word_s;
    logic [DW-1:0]      p2c_word_s;
    logic [DW-1:0]      status_s;
    logic               addr_unused_s;

    // Only the register offset is decoded; the region is qualified by sel_akiko.
    assign addr_unused_s = ^address_in[23:8];

    assign is_data_s = sel_akiko && (address_in[7:1] == ADDR_DATA);
    assign is_ctrl_s = sel_akiko && (address_in[7:1] == ADDR_CTRL);

    // Word writes only; action on the first cycle of the strobe.
    assign wr_both_s = sel_akiko && hwr && lwr;
    assign wr_fire_s = wr_both_s && !wr_prev_r;

    // A DATA read is consumed when its strobe drops; a coincident write wins.
    assign rd_data_s = is_data_s && rd;
    assign rd_adv_s  = rd_prev_r && !rd_data_s && !wr_fire_s;

    // Write side walks bytes in C2P and planes in P2C; the read side is the opposite.
    assign wr_lim_s = mode_r ? PLANES_L : BYTES_L;
    assign rd_lim_s = mode_r ? BYTES_L  : PLANES_L;
    assign full_s   = (wrptr_r == wr_lim_s);
    // A write at the limit wraps and lands in slot 0.
    assign wr_idx_s = (wrptr_r >= wr_lim_s) ? 3'd0 : wrptr_r[2:0];

    // Next-state logic for the buffer, pointers and mode bit.
    always_comb begin
        pix_s   = pix_r;
        wrptr_s = wrptr_r;
        rdptr_s = rdptr_r;
        mode_s  = mode_r;
        if (wr_fire_s && is_ctrl_s) begin
            mode_s  = data_in[0];
            wrptr_s = 4'd0;
            rdptr_s = 4'd0;
        end else if (wr_fire_s && is_data_s) begin
            if (mode_r) begin
                // Planar word: bit wr_idx of every pixel, pixel 0 from the MSB.
                for (int p = 0; p < DW; p++) begin
                    pix_s[p][wr_idx_s] = data_in[DW-1-p];
                end
            end else begin
                // Chunky word: NB consecutive pixel bytes, MSB byte first.
                for (int p = 0; p < DW; p++) begin
                    if ((p / NB) == int'(wr_idx_s)) begin
                        pix_s[p] = data_in[DW-1-8*(p%NB) -: 8];
                    end else begin
                        pix_s[p] = pix_r[p];
                    end
                end
            end
            wrptr_s = (wrptr_r >= wr_lim_s) ? 4'd1 : wrptr_r + 4'd1;
            rdptr_s = 4'd0;
        end else if (rd_adv_s) begin
            rdptr_s = ((rdptr_r + 4'd1) >= rd_lim_s) ? 4'd0 : rdptr_r + 4'd1;
            wrptr_s = 4'd0;
        end else begin
            mode_s = mode_r;
        end
    end

    // State registers with synchronous reset discarding any partial transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_r     <= '0;
            wrptr_r   <= 4'd0;
            rdptr_r   <= 4'd0;
            mode_r    <= 1'b0;
            wr_prev_r <= 1'b0;
            rd_prev_r <= 1'b0;
        end else begin
            pix_r     <= pix_s;
            wrptr_r   <= wrptr_s;
            rdptr_r   <= rdptr_s;
            mode_r    <= mode_s;
            wr_prev_r <= wr_both_s;
            rd_prev_r <= rd_data_s;
        end
    end

    // Build the planar (C2P) and chunky (P2C) views at the current read pointer.
    always_comb begin
        c2p_word_s = '0;
        p2c_word_s = '0;
        for (int p = 0; p < DW; p++) begin
            c2p_word_s[DW-1-p] = pix_r[p][rdptr_r[2:0]];
        end
        for (int p = 0; p < DW; p++) begin
            p2c_word_s[DW-1-8*(p%NB) -: 8] = p2c_word_s[DW-1-8*(p%NB) -: 8]
                | (((p / NB) == int'(rdptr_r[2:0])) ? (pix_r[p] & PLANE_MASK) : 8'h00);
        end
    end

    // STATUS layout: mode, full, six zero bits, read pointer, write pointer.
    always_comb begin
        status_s       = '0;
        status_s[15:0] = {mode_r, full_s, 6'b000000, rdptr_r, wrptr_r};
    end

    // Combinational read mux; idle bus reads as zero.
    always_comb begin
        data_out = '0;
        if (rd && is_data_s) begin
            data_out = mode_r ? p2c_word_s : c2p_word_s;
        end else if (rd && is_ctrl_s) begin
            data_out = status_s;
        end else begin
            data_out = '0;
        end
    end

endmodule

// File: tb/tb_akiko_c2p.sv
// Bench for akiko_c2p: three configurations share one bus; a pixel-array
// model predicts every DATA/STATUS read, and directed sequences pin the model.
module tb_akiko_c2p;

    localparam logic [22:0] A_DATA  = 23'h00001C;
    localparam logic [22:0] A_CTRL  = 23'h00001E;
    localparam logic [22:0] A_OTHER = 23'h000010;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] addr;
    logic [31:0] din;
    logic        rd, hwr, lwr, sel;
    logic [15:0] dout16, dout4;
    logic [31:0] dout32;
    logic [15:0] got16, got4;
    logic [31:0] got32;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_on = 1'b0;

    int    dws[3]   = '{16, 16, 32};
    int    pls[3]   = '{8, 4, 8};
    string names[3] = '{"u16", "u4", "u32"};
    int    mpix[3][32];
    int    mw[3];
    int    mr[3];
    bit    mm[3];
    bit    wprev, rprev;

    logic [15:0] c2p_exp[8] = '{16'h5555, 16'h3333, 16'h0F0F, 16'h00FF,
                                16'h0000, 16'h0000, 16'h0000, 16'h0000};

    always #5 clk = ~clk;

    akiko_c2p #(.DW(16), .PLANES(8)) u16 (
        .clk(clk), .reset(reset), .address_in(addr), .data_in(din[15:0]),
        .data_out(dout16), .rd(rd), .hwr(hwr), .lwr(lwr), .sel_akiko(sel));
    akiko_c2p #(.DW(16), .PLANES(4)) u4 (
        .clk(clk), .reset(reset), .address_in(addr), .data_in(din[15:0]),
        .data_out(dout4), .rd(rd), .hwr(hwr), .lwr(lwr), .sel_akiko(sel));
    akiko_c2p #(.DW(32), .PLANES(8)) u32 (
        .clk(clk), .reset(reset), .address_in(addr), .data_in(din),
        .data_out(dout32), .rd(rd), .hwr(hwr), .lwr(lwr), .sel_akiko(sel));

    function automatic int wlim(int m);
        return mm[m] ? pls[m] : 8;
    endfunction

    function automatic int rlim(int m);
        return mm[m] ? 8 : pls[m];
    endfunction

    // What the bus must read for model m given the present inputs.
    function automatic logic [31:0] model_out(int m);
        int dw, nb, mask;
        logic [31:0] o;
        dw = dws[m]; nb = dw / 8; mask = (1 << pls[m]) - 1; o = '0;
        if (sel && rd && addr[6:0] == 7'h1C) begin
            if (!mm[m]) begin
                for (int p = 0; p < dw; p++)
                    if (((mpix[m][p] >> mr[m]) & 1) == 1) o[dw-1-p] = 1'b1;
            end else begin
                for (int j = 0; j < nb; j++)
                    o = o | 32'((mpix[m][mr[m]*nb+j] & mask) << (dw-8-8*j));
            end
        end else if (sel && rd && addr[6:0] == 7'h1E) begin
            o[15:0] = {mm[m], (mw[m] == wlim(m)), 6'b000000, 4'(mr[m]), 4'(mw[m])};
        end
        return o;
    endfunction

    task automatic model_step();
        bit wnow, wfire, rdd, adv;
        int dw, nb, idx;
        logic [31:0] dv;
        if (reset) begin
            for (int m = 0; m < 3; m++) begin
                for (int p = 0; p < 32; p++) mpix[m][p] = 0;
                mw[m] = 0; mr[m] = 0; mm[m] = 1'b0;
            end
            wprev = 1'b0; rprev = 1'b0;
            return;
        end
        wnow  = sel && hwr && lwr;
        wfire = wnow && !wprev;
        rdd   = sel && rd && (addr[6:0] == 7'h1C);
        adv   = rprev && !rdd && !wfire;
        for (int m = 0; m < 3; m++) begin
            dw = dws[m]; nb = dw / 8;
            dv = (dw == 16) ? {16'h0000, din[15:0]} : din;
            if (wfire && addr[6:0] == 7'h1E) begin
                mm[m] = din[0]; mw[m] = 0; mr[m] = 0;
            end else if (wfire && addr[6:0] == 7'h1C) begin
                idx = (mw[m] == wlim(m)) ? 0 : mw[m];
                if (!mm[m]) begin
                    for (int j = 0; j < nb; j++)
                        mpix[m][idx*nb+j] = int'((dv >> (dw-8-8*j)) & 32'h000000FF);
                end else begin
                    for (int p = 0; p < dw; p++)
                        if (dv[dw-1-p]) mpix[m][p] = mpix[m][p] | (1 << idx);
                        else            mpix[m][p] = mpix[m][p] & ~(1 << idx);
                end
                mw[m] = (mw[m] == wlim(m)) ? 1 : mw[m] + 1;
                mr[m] = 0;
            end else if (adv) begin
                mr[m] = (mr[m] == rlim(m) - 1) ? 0 : mr[m] + 1;
                mw[m] = 0;
            end
        end
        wprev = wnow; rprev = rdd;
    endtask

    always @(posedge clk) model_step();

    task automatic cmp_model(int m, logic [31:0] act);
        logic [31:0] exp;
        exp = model_out(m);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL model_%s t=%0t: got %h want %h", names[m], $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            cmp_model(0, {16'h0000, dout16});
            cmp_model(1, {16'h0000, dout4});
            cmp_model(2, dout32);
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit s, input bit r, input bit h, input bit l,
                         input logic [22:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        sel = s; rd = r; hwr = h; lwr = l; addr = a; din = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 32'h0);
    endtask

    task automatic wr(input logic [22:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, 1'b1, 1'b1, a, d);
        idle();
    endtask

    task automatic do_read(input logic [22:0] a);
        drive(1'b1, 1'b1, 1'b0, 1'b0, a, 32'h0);
        @(negedge clk);
        got16 = dout16; got4 = dout4; got32 = dout32;
        idle();
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; rd = 1'b0; hwr = 1'b0; lwr = 1'b0;
        addr = 23'h0; din = 32'h0;
        @(posedge clk);
        model_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        do_read(A_CTRL);
        check("reset_status", {16'h0000, got16}, 32'h0000);

        // C2P fill of pixels 0..15 then read back the planes.
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 8; i++) wr(A_DATA, 32'(16'h0001 + 16'h0202 * i));
        do_read(A_CTRL);
        check("c2p_status_u16", {16'h0000, got16}, 32'h4008);
        check("c2p_status_u4",  {16'h0000, got4},  32'h4008);
        check("c2p_status_u32", got32, 32'h4008);
        for (int k = 0; k < 8; k++) begin
            do_read(A_DATA);
            check($sformatf("c2p_plane%0d_u16", k), {16'h0000, got16}, {16'h0000, c2p_exp[k]});
            if (k < 5) check($sformatf("c2p4_read%0d_u4", k), {16'h0000, got4},
                             {16'h0000, c2p_exp[k % 4]});
        end

        // Ninth write wraps into slot 0.
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 8; i++) wr(A_DATA, 32'(16'h0001 + 16'h0202 * i));
        wr(A_DATA, 32'h0000FFFF);
        do_read(A_CTRL);
        check("wrap_status_u4", {16'h0000, got4}, 32'h0001);
        do_read(A_DATA);
        check("wrap_plane0_u4", {16'h0000, got4}, 32'hD555);

        // P2C: planes in, chunky words out.
        wr(A_CTRL, 32'h1);
        for (int k = 0; k < 8; k++) wr(A_DATA, {16'h0000, c2p_exp[k]});
        do_read(A_CTRL);
        check("p2c_status_u16", {16'h0000, got16}, 32'hC008);
        for (int w = 0; w < 8; w++) begin
            do_read(A_DATA);
            check($sformatf("p2c_word%0d_u16", w), {16'h0000, got16},
                  32'(16'h0001 + 16'h0202 * w));
        end

        // A held read strobe advances once.
        wr(A_CTRL, 32'h0);
        repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, A_DATA, 32'h0);
        idle();
        idle();
        do_read(A_CTRL);
        check("held_rd_status", {16'h0000, got16}, 32'h0010);

        // Reset mid-fill discards everything.
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 3; i++) wr(A_DATA, 32'h0000A5A5);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        do_read(A_CTRL);
        check("midfill_reset_status", {16'h0000, got16}, 32'h0000);
        do_read(A_DATA);
        check("midfill_reset_data", {16'h0000, got16}, 32'h0000);

        // 32-bit bus, pixel p = p.
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 8; i++) wr(A_DATA, 32'h00010203 + 32'h04040404 * i);
        do_read(A_DATA);
        check("dw32_plane0", got32, 32'h55555555);

        // Randomized traffic, strobes often held for several cycles.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 0) begin
                sel = ($urandom_range(0, 7) != 0);
                rd  = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 3))
                    0:       begin hwr = 1'b1; lwr = 1'b1; end
                    1:       begin hwr = 1'b1; lwr = 1'b0; end
                    2:       begin hwr = 1'b0; lwr = 1'b1; end
                    default: begin hwr = 1'b0; lwr = 1'b0; end
                endcase
                case ($urandom_range(0, 7))
                    0, 1, 2, 3, 4: addr = {16'($urandom), A_DATA[6:0]};
                    5:             addr = {16'($urandom), A_CTRL[6:0]};
                    default:       addr = {16'($urandom), A_OTHER[6:0]};
                endcase
                din = $urandom;
            end
        end
        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/akiko_c2p.md
AKIKO_C2P -- requirements
Module: akiko_c2p

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data bus width in bits; legal values 16, 32.
REQ-002 SHALL have parameter PLANES, default 8, meaning active bitplanes; legal range 1..8.
REQ-003 SHALL have clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have address_in  input  23  word address [23:1].
REQ-006 SHALL have data_in  input  DW  write data.
REQ-007 SHALL have data_out  output  DW  read data.
REQ-008 SHALL have rd  input  1  bus read strobe.
REQ-009 SHALL have hwr  input  1  upper-byte write strobe.
REQ-010 SHALL have lwr  input  1  lower-byte write strobe.
REQ-011 SHALL have sel_akiko  input  1  chip select for the $B8xxxx region.

Function
REQ-012 SHALL decode DATA at address_in[7:1]==7'b0011100 (0x38) and CTRL/STATUS at 7'b0011110 (0x3C), both qualified by sel_akiko.
REQ-013 SHALL hold a buffer of DW pixels x 8 bits; pixel 0 = MSB byte of the first chunky word.
REQ-014 SHALL accept a write only when hwr and lwr are both high; single-byte writes are ignored.
REQ-015 SHALL act once per access: a write is captured on the first cycle of the strobe; a read pointer advances on the cycle after rd&&sel deasserts; held strobes cause no further action.
REQ-016 SHALL provide mode bit M (0 = C2P, 1 = P2C), written via CTRL data_in[0].
REQ-017 SHALL clear wrptr and rdptr on every CTRL write.
REQ-018 C2P write at wrptr w SHALL load pixels w*(DW/8) .. w*(DW/8)+DW/8-1 from data_in, MSB byte first; write limit = 8.
REQ-019 C2P read at rdptr k SHALL return bit k of every pixel, pixel 0 at data_out MSB; read limit = PLANES.
REQ-020 P2C write at wrptr k SHALL load bit k of every pixel, pixel 0 from data_in MSB; write limit = PLANES.
REQ-021 P2C read at rdptr w SHALL return the pixel bytes written by a C2P write at w; bits >= PLANES read 0; read limit = 8.
REQ-022 SHALL set wrptr to 1 on a write at wrptr == limit (wrap; data stored at index 0); otherwise wrptr increments.
REQ-023 SHALL set rdptr to 0 on advance from limit-1; otherwise rdptr increments.
REQ-024 SHALL clear rdptr on any DATA write and clear wrptr on any DATA read advance.
REQ-025 STATUS read SHALL return {M, full, 6'b0, rdptr[3:0], wrptr[3:0]} in bits [15:0], upper bits 0; full = (wrptr == write limit).
REQ-026 data_out SHALL be combinational and 0 when no select is active or rd is low.
REQ-027 A write SHALL win over a read if both occur in the same cycle; the read pointer does not advance.

Reset
REQ-028 Reset SHALL clear the buffer to 0, wrptr = 0, rdptr = 0, M = 0, full = 0, and the strobe edge-detect state.
REQ-029 Reset mid-fill or mid-read SHALL discard all progress with no partial state retained.

Verification
REQ-030 DW=16, C2P: write 0x0001,0x0203,...,0x0E0F -> 8 reads return 0x5555,0x3333,0x0F0F,0x00FF,0,0,0,0; STATUS after writes = 0x4008.
REQ-031 P2C (CTRL=1): write 0x5555,0x3333,0x0F0F,0x00FF,0,0,0,0 -> 8 reads return 0x0001,0x0203,...,0x0E0F.
REQ-032 rd held 3 cycles on DATA -> one advance; STATUS rdptr = 1.
REQ-033 Write 3 words, assert reset -> STATUS = 0x0000 and a DATA read returns 0x0000.
REQ-034 PLANES=4, C2P -> the 5th read returns the plane-0 word again; a 9th write overwrites pixels 0-1 and wrptr = 1.
REQ-035 DW=32, C2P: 8 writes of 0x00010203 + 0x04040404*i -> plane-0 read = 0x55555555.
